// File: rtl/mem_initiator.sv
// ----------------------------------------------------------------------------
// mem_initiator
//
// Initiator-side controller for the ram read/write handshake. Accepts one
// word request at a time from the CPU core, drives the memory address, data
// and strobe lines, follows the ready/exception handshake to completion and
// returns read data or a fault code.
//
// Optional feature macro: MEMIF_TIMEOUT_EN
//   defined   : a cycle counter aborts a transaction that has spent TIMEOUT
//               cycles in ISSUE+WAIT, completing it with fault 11.
//   undefined : no counter; the block waits on the memory indefinitely.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   cpu_req/cpu_we         request valid / 1 = write, 0 = read
//   cpu_addr/cpu_wdata     byte address (word aligned) / write data
//   cpu_ready              high only in IDLE; accept = cpu_req && cpu_ready
//   cpu_done               one-cycle completion pulse
//   cpu_rdata              read data, updated only by a successful read
//   cpu_fault              00 ok, 01 misaligned, 10 mem exception, 11 timeout
//   mem_r_addr/mem_w_addr  read / write address to the memory
//   mem_w_line             write data to the memory
//   mem_read/mem_write     read / write strobes
//   mem_r_line             read data from the memory
//   mem_rrdy/mem_wrdy      read / write side idle (1) or busy (0)
//   mem_exc                memory exception
// ----------------------------------------------------------------------------
module mem_initiator #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_done,
    output logic [DW-1:0] cpu_rdata,
    output logic [1:0]    cpu_fault,
    output logic [AW-1:0] mem_r_addr,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_line,
    output logic          mem_read,
    output logic          mem_write,
    input  logic [DW-1:0] mem_r_line,
    input  logic          mem_rrdy,
    input  logic          mem_wrdy,
    input  logic          mem_exc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_DONE  = 2'b11
    } state_t;

    localparam logic [1:0] FLT_OK      = 2'b00;
    localparam logic [1:0] FLT_MISALGN = 2'b01;
    localparam logic [1:0] FLT_MEMEXC  = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT = 2'b11;

    state_t     state;
    state_t     next_state;
    logic       we_q;
    logic       next_we;
    logic       accept;
    logic       aligned;
    logic       sel_rdy;
    logic       set_fault;
    logic [1:0] next_fault;
    logic       capture_rdata;
    logic       next_rd;
    logic       next_wr;
    logic       timeout_hit;

`ifdef MEMIF_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] tmo_cnt;

    // Cleared when a transaction enters ISSUE, then counts every cycle the
    // transaction stays in ISSUE or WAIT.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == S_IDLE && next_state == S_ISSUE) begin
            tmo_cnt <= '0;
        end else if (state == S_ISSUE || state == S_WAIT) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    assign timeout_hit = (tmo_cnt == TO_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT > 0);
    assign timeout_hit    = 1'b0;
`endif

    assign cpu_ready = (state == S_IDLE);
    assign cpu_done  = (state == S_DONE);
    assign aligned   = (cpu_addr[1:0] == 2'b00);

    // Only the ready line matching the latched direction is ever looked at.
    assign sel_rdy = we_q ? mem_wrdy : mem_rrdy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode. Exception beats ready, ready beats timeout.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        set_fault     = 1'b0;
        next_fault    = FLT_OK;
        capture_rdata = 1'b0;
        case (state)
            S_IDLE: begin
                if (cpu_req) begin
                    accept = 1'b1;
                    if (!aligned) begin
                        next_state = S_DONE;
                        set_fault  = 1'b1;
                        next_fault = FLT_MISALGN;
                    end else begin
                        next_state = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (mem_exc) begin
                    next_state = S_DONE;
                    set_fault  = 1'b1;
                    next_fault = FLT_MEMEXC;
                end else if (!sel_rdy) begin
                    next_state = S_WAIT;
                end else if (timeout_hit) begin
                    next_state = S_DONE;
                    set_fault  = 1'b1;
                    next_fault = FLT_TIMEOUT;
                end
            end
            S_WAIT: begin
                if (mem_exc) begin
                    next_state = S_DONE;
                    set_fault  = 1'b1;
                    next_fault = FLT_MEMEXC;
                end else if (sel_rdy) begin
                    next_state    = S_DONE;
                    set_fault     = 1'b1;
                    next_fault    = FLT_OK;
                    capture_rdata = !we_q;
                end else if (timeout_hit) begin
                    next_state = S_DONE;
                    set_fault  = 1'b1;
                    next_fault = FLT_TIMEOUT;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Strobes are registered from the next state so they only move on a
    // state transition and cannot glitch between edges.
    always_comb begin
        next_we = accept ? cpu_we : we_q;
        next_rd = 1'b0;
        next_wr = 1'b0;
        if (next_state == S_ISSUE || next_state == S_WAIT) begin
            next_rd = !next_we;
            next_wr = next_we;
        end
    end

    // Datapath registers. Address/data outputs are loaded only by an accepted
    // aligned request and otherwise keep their last value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_r_addr <= '0;
            mem_w_addr <= '0;
            mem_w_line <= '0;
            cpu_rdata  <= '0;
            cpu_fault  <= FLT_OK;
        end else begin
            mem_read  <= next_rd;
            mem_write <= next_wr;
            if (accept) begin
                we_q <= cpu_we;
            end
            if (accept && aligned) begin
                if (cpu_we) begin
                    mem_w_addr <= cpu_addr;
                    mem_w_line <= cpu_wdata;
                end else begin
                    mem_r_addr <= cpu_addr;
                end
            end
            if (set_fault) begin
                cpu_fault <= next_fault;
            end
            if (capture_rdata) begin
                cpu_rdata <= mem_r_line;
            end
        end
    end

endmodule
